// File: rtl/tblink_rpc_invoke_initiator.sv
// TBLink RPC invoke initiator: serialises user method calls into invoke frames and
// matches returning response frames against a small table of outstanding call IDs.
module tblink_rpc_invoke_initiator #(
   parameter int DATA_W          = 32,
   parameter int ID_W            = 8,
   parameter int METHOD_W        = 8,
   parameter int MAX_PARAMS      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clock_i,
   input  logic                                 reset_n_i,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic [METHOD_W-1:0]                  req_method_i,
   input  logic [3:0]                           req_nparams_i,
   input  logic                                 req_blocking_i,
   input  logic [MAX_PARAMS*DATA_W-1:0]         req_params_i,
   output logic [ID_W-1:0]                      req_call_id_o,
   output logic                                 tx_valid_o,
   input  logic                                 tx_ready_i,
   output logic [DATA_W-1:0]                    tx_data_o,
   output logic                                 tx_last_o,
   input  logic                                 rx_valid_i,
   output logic                                 rx_ready_o,
   input  logic [DATA_W-1:0]                    rx_data_i,
   input  logic                                 rx_last_i,
   output logic                                 rsp_valid_o,
   input  logic                                 rsp_ready_i,
   output logic [ID_W-1:0]                      rsp_call_id_o,
   output logic [DATA_W-1:0]                    rsp_retval_o,
   output logic                                 rsp_err_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 err_unknown_id_o,
   output logic                                 err_proto_o
);

   localparam int TIDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int PIDX_W = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);
   localparam logic [3:0] MAXP = 4'(MAX_PARAMS);

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_HDR   = 2'd1;
   localparam logic [1:0] TX_PARAM = 2'd2;

   localparam logic [1:0] R_HDR  = 2'd0;
   localparam logic [1:0] R_DATA = 2'd1;
   localparam logic [1:0] R_OUT  = 2'd2;
   localparam logic [1:0] R_DROP = 2'd3;

   // ---------------- state ----------------
   logic [1:0]                          tx_st_q, tx_st_d;
   logic [3:0]                          pidx_q, pidx_d;
   logic [METHOD_W-1:0]                 meth_q;
   logic [3:0]                          np_q;
   logic                                blk_q;
   logic [ID_W-1:0]                     cid_q;
   logic [MAX_PARAMS-1:0][DATA_W-1:0]   par_q;
   logic [ID_W-1:0]                     id_cnt_q, id_cnt_d;

   logic [MAX_OUTSTANDING-1:0]            tbl_vld_q, tbl_vld_d;
   logic [MAX_OUTSTANDING-1:0][ID_W-1:0]  tbl_id_q, tbl_id_d;
   logic [CNT_W-1:0]                      out_q, out_d;

   logic [1:0]         rx_st_q, rx_st_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]  rsp_ret_q, rsp_ret_d;
   logic               rsp_err_q, rsp_err_d;
   logic [TIDX_W-1:0]  rsp_idx_q, rsp_idx_d;
   logic               drop_rsp_q, drop_rsp_d;
   logic               err_unk_q, err_unk_d;
   logic               err_proto_q, err_proto_d;

   // ---------------- call table lookup ----------------
   logic              next_busy, found_free, rx_hit;
   logic [TIDX_W-1:0] free_idx, rx_idx;
   logic [ID_W-1:0]   rx_id;

   assign rx_id = rx_data_i[ID_W-1:0];

   always_comb begin
      next_busy  = 1'b0;
      found_free = 1'b0;
      free_idx   = '0;
      rx_hit     = 1'b0;
      rx_idx     = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (tbl_vld_q[i]) begin
            if (tbl_id_q[i] == id_cnt_q) next_busy = 1'b1;
            if (tbl_id_q[i] == rx_id) begin
               rx_hit = 1'b1;
               rx_idx = TIDX_W'(i);
            end
         end else if (!found_free) begin
            found_free = 1'b1;
            free_idx   = TIDX_W'(i);
         end
      end
   end

   // ---------------- TX path ----------------
   logic              accept, tx_hs;
   logic [DATA_W-1:0] hdr;
   logic [3:0]        np_in;

   assign req_ready_o   = (tx_st_q == TX_IDLE) && found_free && !next_busy;
   assign accept        = req_valid_i && req_ready_o;
   assign tx_hs         = tx_valid_o && tx_ready_i;
   assign np_in         = (req_nparams_i > MAXP) ? MAXP : req_nparams_i;
   assign req_call_id_o = id_cnt_q;

   always_comb begin
      hdr = '0;
      hdr[DATA_W-1 -: 2]         = 2'b01;
      hdr[ID_W+METHOD_W+4]       = blk_q;
      hdr[ID_W+METHOD_W +: 4]    = np_q;
      hdr[ID_W +: METHOD_W]      = meth_q;
      hdr[ID_W-1:0]              = cid_q;
   end

   always_comb begin
      tx_valid_o = 1'b0;
      tx_data_o  = '0;
      tx_last_o  = 1'b0;
      case (tx_st_q)
         TX_HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = hdr;
            tx_last_o  = (np_q == 4'd0);
         end
         TX_PARAM: begin
            tx_valid_o = 1'b1;
            tx_data_o  = par_q[pidx_q[PIDX_W-1:0]];
            tx_last_o  = (pidx_q == np_q - 4'd1);
         end
         default: ;
      endcase
   end

   always_comb begin
      tx_st_d  = tx_st_q;
      pidx_d   = pidx_q;
      id_cnt_d = accept ? id_cnt_q + ID_W'(1) : id_cnt_q;
      case (tx_st_q)
         TX_IDLE:  if (accept) tx_st_d = TX_HDR;
         TX_HDR:   if (tx_hs) begin
                      tx_st_d = (np_q == 4'd0) ? TX_IDLE : TX_PARAM;
                      pidx_d  = 4'd0;
                   end
         TX_PARAM: if (tx_hs) begin
                      if (tx_last_o) tx_st_d = TX_IDLE;
                      else           pidx_d  = pidx_q + 4'd1;
                   end
         default:  tx_st_d = TX_IDLE;
      endcase
   end

   // ---------------- RX path ----------------
   logic rx_hs, rsp_hs, hdr_ok;

   assign rx_ready_o  = (rx_st_q != R_OUT);
   assign rsp_valid_o = (rx_st_q == R_OUT);
   assign rx_hs       = rx_valid_i && rx_ready_o;
   assign rsp_hs      = rsp_valid_o && rsp_ready_i;
   assign hdr_ok      = (rx_data_i[DATA_W-1 -: 2] == 2'b10) && rx_hit;

   always_comb begin
      rx_st_d     = rx_st_q;
      rsp_id_d    = rsp_id_q;
      rsp_ret_d   = rsp_ret_q;
      rsp_err_d   = rsp_err_q;
      rsp_idx_d   = rsp_idx_q;
      drop_rsp_d  = drop_rsp_q;
      err_unk_d   = 1'b0;
      err_proto_d = 1'b0;
      case (rx_st_q)
         R_HDR: if (rx_hs) begin
            if (!hdr_ok) begin
               err_unk_d  = 1'b1;
               drop_rsp_d = 1'b0;
               if (!rx_last_i) rx_st_d = R_DROP;
            end else begin
               rsp_id_d  = rx_id;
               rsp_err_d = rx_data_i[DATA_W-3];
               rsp_idx_d = rx_idx;
               rsp_ret_d = '0;
               rx_st_d   = rx_last_i ? R_OUT : R_DATA;
            end
         end
         R_DATA: if (rx_hs) begin
            rsp_ret_d = rx_data_i;
            if (rx_last_i) rx_st_d = R_OUT;
            else begin
               // over-long response: keep the retval, drain the tail, then deliver
               err_proto_d = 1'b1;
               drop_rsp_d  = 1'b1;
               rx_st_d     = R_DROP;
            end
         end
         R_DROP: if (rx_hs && rx_last_i) rx_st_d = drop_rsp_q ? R_OUT : R_HDR;
         R_OUT:  if (rsp_hs) rx_st_d = R_HDR;
         default: rx_st_d = R_HDR;
      endcase
   end

   assign rsp_call_id_o    = rsp_id_q;
   assign rsp_retval_o     = rsp_ret_q;
   assign rsp_err_o        = rsp_err_q;
   assign err_unknown_id_o = err_unk_q;
   assign err_proto_o      = err_proto_q;
   assign outstanding_o    = out_q;

   // ---------------- table update ----------------
   // alloc always lands on a free slot and free on a valid one, so both may apply together
   always_comb begin
      tbl_vld_d = tbl_vld_q;
      tbl_id_d  = tbl_id_q;
      out_d     = out_q;
      if (rsp_hs) tbl_vld_d[rsp_idx_q] = 1'b0;
      if (accept) begin
         tbl_vld_d[free_idx] = 1'b1;
         tbl_id_d[free_idx]  = id_cnt_q;
      end
      if (accept && !rsp_hs)      out_d = out_q + CNT_W'(1);
      else if (rsp_hs && !accept) out_d = out_q - CNT_W'(1);
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         tx_st_q     <= TX_IDLE;
         pidx_q      <= '0;
         meth_q      <= '0;
         np_q        <= '0;
         blk_q       <= 1'b0;
         cid_q       <= '0;
         par_q       <= '0;
         id_cnt_q    <= '0;
         tbl_vld_q   <= '0;
         tbl_id_q    <= '0;
         out_q       <= '0;
         rx_st_q     <= R_HDR;
         rsp_id_q    <= '0;
         rsp_ret_q   <= '0;
         rsp_err_q   <= 1'b0;
         rsp_idx_q   <= '0;
         drop_rsp_q  <= 1'b0;
         err_unk_q   <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         tx_st_q     <= tx_st_d;
         pidx_q      <= pidx_d;
         id_cnt_q    <= id_cnt_d;
         if (accept) begin
            meth_q <= req_method_i;
            np_q   <= np_in;
            blk_q  <= req_blocking_i;
            cid_q  <= id_cnt_q;
            par_q  <= req_params_i;
         end
         tbl_vld_q   <= tbl_vld_d;
         tbl_id_q    <= tbl_id_d;
         out_q       <= out_d;
         rx_st_q     <= rx_st_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ret_q   <= rsp_ret_d;
         rsp_err_q   <= rsp_err_d;
         rsp_idx_q   <= rsp_idx_d;
         drop_rsp_q  <= drop_rsp_d;
         err_unk_q   <= err_unk_d;
         err_proto_q <= err_proto_d;
      end
   end

endmodule
